// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  // Bubble encoding: addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Clear the two byte-offset bits of an address so it points at a word.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC / next-state selection for the fetch stage.
// Priority: redirect > HALT hold > stall > normal advance.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int IMEM_BYTES = 128
) (
  input  logic [XLEN-1:0] pc,
  input  fetch_state_t    state,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] next_pc,
  output fetch_state_t    next_state,
  output logic            load_bubble,
  output logic            set_misalign
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - INST_BYTES);

  logic [XLEN-1:0] w_aligned;

  // Select the following PC, state and IF/ID update kind for this cycle.
  always_comb begin
    w_aligned    = align_word(redirect_target);
    next_pc      = pc;
    next_state   = state;
    load_bubble  = 1'b0;
    set_misalign = 1'b0;
    if (redirect) begin
      next_pc      = w_aligned;
      load_bubble  = 1'b1;
      set_misalign = (redirect_target[1:0] != 2'b00);
      if (w_aligned <= LAST_PC) begin
        next_state = RUN;
      end else begin
        next_state = HALT;
      end
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            next_pc = pc;
          end else if (pc <= LAST_PC) begin
            next_pc = pc + XLEN'(INST_BYTES);
          end else begin
            next_state  = HALT;
            load_bubble = 1'b1;
          end
        end
        HALT: begin
          load_bubble = 1'b1;
        end
        default: begin
          next_state  = HALT;
          load_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and registers the returned instruction into IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_BYTES = 128,
  parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_inst,
  output logic            ifid_valid,
  output logic            halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
`endif
  output logic            misalign_err
);

  logic [XLEN-1:0] r_pc;
  fetch_state_t    r_state;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_inst;
  logic            r_ifid_valid;
  logic            r_halted;
  logic            r_misalign;

  logic [XLEN-1:0] w_next_pc;
  fetch_state_t    w_next_state;
  logic            w_load_bubble;
  logic            w_set_misalign;
  logic            w_load_inst;
  logic            w_stall_cycle;

  fetch_next_pc #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_pc (
    .pc              (r_pc),
    .state           (r_state),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .next_pc         (w_next_pc),
    .next_state      (w_next_state),
    .load_bubble     (w_load_bubble),
    .set_misalign    (w_set_misalign)
  );

  // A real instruction enters IF/ID only on an unstalled, non-bubble RUN edge;
  // a stalled RUN edge without redirect is the only case where IF/ID holds.
  assign w_load_inst   = (r_state == RUN) && !stall && !w_load_bubble;
  assign w_stall_cycle = (r_state == RUN) && stall && !redirect;

  // PC, FSM state, IF/ID register and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_state      <= RUN;
      r_ifid_pc    <= '0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_pc     <= w_next_pc;
      r_state  <= w_next_state;
      r_halted <= (w_next_state == HALT);
      if (w_set_misalign) begin
        r_misalign <= 1'b1;
      end
      if (w_load_bubble) begin
        r_ifid_pc    <= '0;
        r_ifid_inst  <= NOP_INST;
        r_ifid_valid <= 1'b0;
      end else if (w_load_inst) begin
        r_ifid_pc    <= r_pc;
        r_ifid_inst  <= imem_inst;
        r_ifid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_perf_fetch_cnt;
  logic [XLEN-1:0] r_perf_stall_cnt;

  // Free-running wrap-around counters of valid fetches and RUN-state stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_load_inst) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_stall_cycle) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall_cycle;
`endif

  assign imem_addr    = r_pc;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_inst    = r_ifid_inst;
  assign ifid_valid   = r_ifid_valid;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the memory read address.
- Captures the returned 32-bit instruction into an IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect with bubble insertion, end-of-memory halt, and misaligned-target detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes; the last legal fetch address is IMEM_BYTES-4.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect  in  1  taken branch/jump from execute.
- redirect_target  in  32  byte address for the redirect.
- imem_addr  out  32  read address to instruction memory (= pc, combinational).
- imem_inst  in  32  instruction returned by instruction memory (combinational read).
- ifid_pc  out  32  PC of the instruction held in IF/ID.
- ifid_inst  out  32  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch is in the HALT state.
- misalign_err  out  1  sticky: a redirect target with [1:0]!=0 was received.

Behaviour:
- Reset values:
  - pc=RESET_PC
  - ifid_pc=0, ifid_inst=NOP_INST, ifid_valid=0
  - halted=0, misalign_err=0
  - state=RUN
- imem_addr=pc at all times. The memory read is combinational; the instruction is registered into IF/ID at the same edge that advances pc. Fetch-to-decode latency is 1 cycle.
- Priority per edge: rst > redirect > stall > normal advance.
- FSM states: RUN, HALT.
- RUN, normal (no stall, no redirect):
  - If pc <= IMEM_BYTES-4: ifid <= {pc, imem_inst, 1}; pc <= pc+4 (32-bit modular; wrap to 0 is legal arithmetic).
  - If pc > IMEM_BYTES-4: go to HALT; ifid <= bubble {0, NOP_INST, 0}; pc holds.
- RUN, stall: pc and all ifid_* hold; no state change.
- Redirect (either state, overrides stall):
  - pc <= {redirect_target[31:2], 2'b00}.
  - ifid <= bubble.
  - If redirect_target[1:0]!=0, set misalign_err (cleared only by rst).
  - Next state: RUN if the aligned target <= IMEM_BYTES-4, else HALT.
- HALT: pc holds, ifid = bubble, halted=1. Stall is ignored. Only redirect or rst leave HALT.
- Simultaneous redirect+stall: redirect wins; the bubble is written even though decode is stalled.
- Reset mid-stall or in HALT: full reset values on the next edge regardless of other inputs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every edge where a valid instruction enters IF/ID.
  - perf_stall_cnt increments on every RUN-state edge with stall=1 and redirect=0.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg contains:
  - XLEN=32
  - NOP_INST default constant
  - INST_BYTES=4
  - enum fetch_state_t {RUN, HALT}
- One sub-module, fetch_next_pc: a combinational next-PC/next-state mux.
  - Inputs: pc, state, stall, redirect, redirect_target.
  - Outputs: next_pc, next_state, load_bubble, set_misalign.
- fetch_unit keeps all registers.

Test Plan:
- Reset then 4 free-running cycles with imem returning A,B,C,D → ifid_pc 0,4,8,C; ifid_inst A,B,C,D; ifid_valid=1 from cycle 1; imem_addr 0→4→8→C→10.
- stall=1 for 3 cycles at pc=8 → imem_addr stays 8; ifid holds {4,B,1}; resumes with {8,C,1}.
- redirect=1, target=0x40, with stall=1 same cycle → next cycle pc=0x40, ifid={0,0x13,0}; following cycle ifid_pc=0x40, valid=1.
- Run to pc=0x7C → 0x7C fetched valid; next edge HALT, halted=1, pc=0x80, ifid bubble; stall toggling has no effect; redirect to 0x10 → RUN, pc=0x10.
- redirect target=0x22 → pc=0x20, misalign_err=1 and stays 1 across later redirects until rst.
- rst asserted while halted with misalign_err=1 → all outputs return to reset values; with FETCH_PERF_CNT_EN, both counters=0 and perf_fetch_cnt=3 after 3 unstalled fetches.
